// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter.
// Accepts WIDTH-bit words over valid/ready and shifts each one out MSB-first.
// Every bit is held for BIT_CYCLES clocks and comes with a valid strobe.
// frame_start marks the MSB of each word.
// A one-word holding register lets frames run back-to-back with no idle gap.
module piso_serializer #(
   parameter int WIDTH      = 4,
   parameter int BIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]    div_cnt_q, div_cnt_d;

   logic accept;
   logic div_last;
   logic last_tick;

   // The holding register is the only thing that can refuse a word.
   assign accept    = load_valid && !hold_full_q;
   assign div_last  = (div_cnt_q == DIV_LAST);
   assign last_tick = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST) && div_last;

   // Next-state, shifter and holding-register update.
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               sh_d      = parallel_in;
               bit_cnt_d = '0;
               div_cnt_d = '0;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            if (div_last) begin
               sh_d      = {sh_q[WIDTH-2:0], 1'b0};
               div_cnt_d = '0;
               bit_cnt_d = bit_cnt_q + BW'(1);
            end else begin
               div_cnt_d = div_cnt_q + DW'(1);
            end

            if (last_tick) begin
               // Frame ends here: chain the held word, a fresh word, or go idle.
               bit_cnt_d = '0;
               div_cnt_d = '0;
               if (hold_full_q) begin
                  sh_d        = hold_q;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  sh_d = parallel_in;
               end else begin
                  state_d = IDLE;
               end
            end else if (accept) begin
               // The shifter is busy, so the word waits in hold.
               hold_d      = parallel_in;
               hold_full_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Control and shifter registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sh_q        <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
      end
   end

   // Holding data needs no reset; it is only meaningful while hold_full is set.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   assign load_ready   = !hold_full_q;
   assign serial_valid = (state_q == SHIFT);
   assign serial_out   = (state_q == SHIFT) && sh_q[WIDTH-1];
   assign frame_start  = (state_q == SHIFT) && (bit_cnt_q == '0);
   assign busy         = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (BIT_CYCLES=1 and 2) checked every
// cycle against a word-queue model, plus directed literal expectations.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pin1, pin2;
   logic       lv1, lv2;
   logic       rdy1, so1, sv1, fs1, bsy1;
   logic       rdy2, so2, sv2, fs2, bsy2;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4), .BIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .parallel_in(pin1), .load_valid(lv1),
      .load_ready(rdy1), .serial_out(so1), .serial_valid(sv1),
      .frame_start(fs1), .busy(bsy1)
   );

   piso_serializer #(.WIDTH(4), .BIT_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .parallel_in(pin2), .load_valid(lv2),
      .load_ready(rdy2), .serial_out(so2), .serial_valid(sv2),
      .frame_start(fs2), .busy(bsy2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: per instance, a list of up to two words (in flight + waiting)
   // and the cycle position inside the current frame.
   logic [3:0] mw [2][2];
   int         mcnt [2] = '{0, 0};
   int         mt   [2] = '{0, 0};
   logic       chk_en = 1'b0;

   always @(posedge clk) begin : model
      logic       lv;
      logic [3:0] pin;
      logic       acc;
      int         bc;
      for (int k = 0; k < 2; k++) begin
         lv  = (k == 0) ? lv1 : lv2;
         pin = (k == 0) ? pin1 : pin2;
         bc  = (k == 0) ? 1 : 2;
         if (rst) begin
            mcnt[k] = 0;
            mt[k]   = 0;
         end else begin
            acc = lv && (mcnt[k] < 2);
            if (mcnt[k] > 0) begin
               mt[k] = mt[k] + 1;
               if (mt[k] == 4 * bc) begin
                  mt[k]    = 0;
                  mw[k][0] = mw[k][1];
                  mcnt[k]  = mcnt[k] - 1;
               end
            end
            if (acc) begin
               mw[k][mcnt[k]] = pin;
               mcnt[k]        = mcnt[k] + 1;
            end
         end
      end
   end

   logic [31:0] s1_bits, f1_bits, s2_bits, f2_bits;
   int          s1_n, s2_n;

   // Compare against the model on the falling edge, and log the serial streams.
   always @(negedge clk) begin : cmp
      logic [3:0] w;
      logic       eb, ev, ef, er;
      int         bc;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            bc = (k == 0) ? 1 : 2;
            ev = (mcnt[k] > 0);
            w  = mw[k][0];
            eb = ev ? w[3 - mt[k] / bc] : 1'b0;
            ef = ev && (mt[k] < bc);
            er = (mcnt[k] < 2);
            chk($sformatf("u%0d serial_out", k + 1),   32'((k == 0) ? so1  : so2),  32'(eb));
            chk($sformatf("u%0d serial_valid", k + 1), 32'((k == 0) ? sv1  : sv2),  32'(ev));
            chk($sformatf("u%0d frame_start", k + 1),  32'((k == 0) ? fs1  : fs2),  32'(ef));
            chk($sformatf("u%0d load_ready", k + 1),   32'((k == 0) ? rdy1 : rdy2), 32'(er));
            chk($sformatf("u%0d busy", k + 1),         32'((k == 0) ? bsy1 : bsy2), 32'(ev));
         end
      end
      if (sv1 === 1'b1) begin
         s1_bits = {s1_bits[30:0], so1};
         f1_bits = {f1_bits[30:0], fs1};
         s1_n++;
      end
      if (sv2 === 1'b1) begin
         s2_bits = {s2_bits[30:0], so2};
         f2_bits = {f2_bits[30:0], fs2};
         s2_n++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] words [3] = '{4'b1101, 4'b0110, 4'b1001};
   logic [3:0] exp_w;
   int         idx;
   logic       r;
   logic       saw_low;

   initial begin
      rst  = 1'b1;
      lv1  = 1'b0;
      lv2  = 1'b0;
      pin1 = '0;
      pin2 = '0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle serial_out", 32'(so1), 0);
         chk("idle serial_valid", 32'(sv1), 0);
         chk("idle frame_start", 32'(fs1), 0);
         chk("idle busy", 32'(bsy1), 0);
         chk("idle load_ready", 32'(rdy1), 1);
      end

      // Single word 1101
      pin1 = 4'b1101;
      lv1  = 1'b1;
      tick();
      lv1   = 1'b0;
      exp_w = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         chk("single bit", 32'(so1), 32'(exp_w[3-i]));
         chk("single frame_start", 32'(fs1), (i == 0) ? 1 : 0);
         chk("single valid", 32'(sv1), 1);
         tick();
      end
      chk("single valid after", 32'(sv1), 0);
      chk("single serial_out after", 32'(so1), 0);

      // Back-to-back words with load_valid held; third word waits on load_ready
      s1_n    = 0;
      s1_bits = '0;
      f1_bits = '0;
      idx     = 0;
      saw_low = 1'b0;
      pin1    = words[0];
      lv1     = 1'b1;
      for (int i = 0; i < 60 && idx < 3; i++) begin
         r = rdy1;
         tick();
         if (r) begin
            idx++;
            if (idx < 3) pin1 = words[idx];
            else lv1 = 1'b0;
         end
         if (!rdy1) saw_low = 1'b1;
      end
      chk("b2b words accepted", 32'(idx), 3);
      for (int i = 0; i < 60 && (sv1 || bsy1); i++) tick();
      chk("b2b drained", 32'(bsy1), 0);
      chk("b2b bit count", 32'(s1_n), 12);
      chk("b2b stream", {20'd0, s1_bits[11:0]}, 32'b1101_0110_1001);
      chk("b2b frame_start", {20'd0, f1_bits[11:0]}, 32'b1000_1000_1000);
      chk("b2b load_ready went low", 32'(saw_low), 1);

      // BIT_CYCLES=2, word 1001
      s2_n    = 0;
      s2_bits = '0;
      f2_bits = '0;
      pin2    = 4'b1001;
      lv2     = 1'b1;
      tick();
      lv2 = 1'b0;
      for (int i = 0; i < 40 && sv2; i++) tick();
      chk("bc2 drained", 32'(sv2), 0);
      chk("bc2 bit count", 32'(s2_n), 8);
      chk("bc2 stream", {24'd0, s2_bits[7:0]}, 32'b1100_0011);
      chk("bc2 frame_start", {24'd0, f2_bits[7:0]}, 32'b1100_0000);

      // Reset after two bits of 1101 with 0110 waiting in hold
      pin1 = 4'b1101;
      lv1  = 1'b1;
      tick();
      pin1 = 4'b0110;
      tick();
      lv1 = 1'b0;
      chk("pre-reset load_ready", 32'(rdy1), 0);
      chk("pre-reset serial_out", 32'(so1), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("reset serial_out", 32'(so1), 0);
      chk("reset serial_valid", 32'(sv1), 0);
      chk("reset frame_start", 32'(fs1), 0);
      chk("reset busy", 32'(bsy1), 0);
      chk("reset load_ready", 32'(rdy1), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post-reset valid", 32'(sv1), 0);
         chk("post-reset busy", 32'(bsy1), 0);
      end
      s1_n    = 0;
      s1_bits = '0;
      f1_bits = '0;
      pin1    = 4'b0110;
      lv1     = 1'b1;
      tick();
      lv1 = 1'b0;
      for (int i = 0; i < 40 && sv1; i++) tick();
      chk("after-reset drained", 32'(sv1), 0);
      chk("after-reset bit count", 32'(s1_n), 4);
      chk("after-reset stream", {28'd0, s1_bits[3:0]}, 32'b0110);
      chk("after-reset frame_start", {28'd0, f1_bits[3:0]}, 32'b1000);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter for the shift-register family: it accepts WIDTH-bit words over a valid/ready handshake and shifts each one out MSB-first on a single serial line. Each output bit is accompanied by a valid strobe, and a start-of-frame marker flags the first bit of every word. A one-word holding register allows back-to-back words to be sent with no idle gap. It is the transmit end paired with the team's serial-in/parallel-out receiver.

## Interface
Parameters:
- WIDTH, 4, word width in bits; must be ≥ 2.
- BIT_CYCLES, 1, clock cycles each bit is held on serial_out; must be ≥ 1.

Ports:
- clk  input  1  single clock; everything updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- parallel_in  input  WIDTH  word to transmit; sampled only on an accept edge.
- load_valid  input  1  parallel_in holds a word.
- load_ready  output  1  block can take a word; equals !hold_full.
- serial_out  output  1  current serial bit, MSB first; 0 when idle.
- serial_valid  output  1  serial_out carries a frame bit.
- frame_start  output  1  high for the BIT_CYCLES cycles of bit WIDTH-1 (the MSB) of each frame.
- busy  output  1  shifter active, or holding register full.

## Operation
- Storage:
  - shift register sh[WIDTH-1:0];
  - holding register hold[WIDTH-1:0] with flag hold_full;
  - bit counter bit_cnt (0..WIDTH-1);
  - divider div_cnt (0..BIT_CYCLES-1).
- States: IDLE and SHIFT.
- Accept: load_valid && load_ready at a rising edge. parallel_in is ignored at all other times.
- last_tick: state is SHIFT, bit_cnt == WIDTH-1 and div_cnt == BIT_CYCLES-1.
- Shifter free at an edge: state is IDLE, or last_tick is true.
- IDLE:
  - On accept, parallel_in loads directly into sh.
  - Set bit_cnt = 0 and div_cnt = 0, then go to SHIFT.
  - hold stays empty.
- SHIFT:
  - serial_out = sh[WIDTH-1].
  - Each edge where div_cnt == BIT_CYCLES-1: shift sh left by one, reset div_cnt to 0, increment bit_cnt.
  - Otherwise, increment div_cnt.
- At last_tick:
  - If hold_full: hold moves to sh, hold_full clears, counters reset to 0, state stays SHIFT. The next frame follows with no gap.
  - Else, if accept occurs on the same edge: parallel_in loads into sh, state stays SHIFT.
  - Else: go to IDLE.
- Accept while the shifter is not free: the word goes into hold and hold_full is set.
- Simultaneous accept and hold-to-shifter transfer cannot occur, because load_ready is 0 whenever hold_full is 1.
- serial_valid = (state == SHIFT).
- frame_start = (state == SHIFT) && (bit_cnt == 0).
- Reset, at any time including mid-frame:
  - abort the frame and discard hold;
  - state = IDLE, sh = 0, counters = 0, hold_full = 0.
  - No accept is recorded on a reset edge.

## Timing
- Values after a reset edge: serial_out 0, serial_valid 0, frame_start 0, busy 0, load_ready 1.
- Latency: a word accepted at edge E with the shifter free drives its MSB in the cycle after E, with serial_valid = 1 and frame_start = 1.
- Frame length: WIDTH*BIT_CYCLES cycles.
- Continuous loading: with load_valid held high, output is continuous with no gap. Throughput is one word per WIDTH*BIT_CYCLES cycles.
- load_ready:
  - falls in the cycle after a word is written into hold;
  - rises in the cycle after hold transfers to sh.
- busy:
  - rises in the cycle after the first accept;
  - falls in the cycle after last_tick when no word follows.
- serial_out is registered; no input-to-output combinational path exists.
- load_ready is derived only from the hold_full register.

## Test plan
- Reset, then idle for 5 cycles -> all outputs at their reset values; load_ready = 1 throughout.
- WIDTH=4, BIT_CYCLES=1, single word 4'b1101 -> over 4 consecutive cycles:
  - serial_out = 1, 1, 0, 1;
  - frame_start only in the first cycle;
  - serial_valid = 0 in the following cycle.
- Back-to-back words 4'b1101, 4'b0110, 4'b1001 with load_valid held high -> 12 contiguous valid bits 1101 0110 1001; frame_start at cycles 0, 4 and 8; load_ready low while hold is full.
- BIT_CYCLES=2, word 4'b1001 -> serial_out = 1, 1, 0, 0, 0, 0, 1, 1; frame_start high for the first 2 cycles.
- Hold full with a third word presented -> the third word is not accepted until load_ready rises; it is then sent intact after the second word.
- Assert rst mid-frame, after 2 bits of 4'b1101 -> outputs return to reset values in the next cycle, and the held word is discarded. A new word 4'b0110 then transmits correctly.
